// File: rtl/csi_lane_deskew_merger.sv
// Multi-lane CSI-2 HS receiver front end: per-lane SoT detection, inter-lane deskew,
// and merge of aligned lane bytes into sop/eop-delimited words behind a FWFT output FIFO.
module csi_lane_deskew_merger #(
  parameter int         LANES      = 4,
  parameter int         SKEW_MAX   = 4,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hB8
) (
  input  logic               hs_clk,
  input  logic               rst,
  input  logic [LANES-1:0]   lane_en,
  input  logic [8*LANES-1:0] lane_data,
  input  logic [LANES-1:0]   lane_valid,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_byte_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic               skew_err,
  output logic               ovf_err,
  input  logic               err_clr,
  output logic               busy
);

  localparam int W   = 8 * LANES;
  localparam int SPW = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;
  localparam int SCW = $clog2(SKEW_MAX + 1);
  localparam int FPW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HUNT, STREAM, WAIT_IDLE} state_t;
  state_t state, state_nxt;

  logic [LANES-1:0] lane_seen, armed, arm_ok, arm_hit, sb_push, sb_ne, sb_full, sb_wr;
  logic [SCW-1:0]   cnt, cnt_inc;
  logic [W-1:0]     word_asm, stage_data;
  logic             stage_v, stage_sop, first_word;
  logic             all_ne, all_armed, lv_idle, sb_ovf;
  logic             latch_en, flush, clr_arm, pop_word, fifo_push, push_eop, skew_evt;

  logic [7:0]       sb_mem [LANES][SKEW_MAX];
  logic [SPW-1:0]   sb_wp  [LANES];
  logic [SPW-1:0]   sb_rp  [LANES];
  logic [SCW-1:0]   sb_cnt [LANES];

  logic [W+1:0]     fifo_mem [FIFO_DEPTH];
  logic [FPW-1:0]   f_wp, f_rp;
  logic [FPW:0]     f_cnt;
  logic             f_full, f_pop, f_wr, fifo_drop;
  logic [W+1:0]     f_head;

  function automatic logic [SPW-1:0] wrap_inc(input logic [SPW-1:0] p);
    return (p == SPW'(SKEW_MAX - 1)) ? '0 : p + 1'b1;
  endfunction

  // A lane arms only on a sync byte that opens its burst (lane_valid was low the cycle before).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    arm_hit  = '0;
    sb_push  = '0;
    sb_ne    = '0;
    sb_full  = '0;
    word_asm = '0;
    arm_ok   = (state == IDLE) ? lane_en : ((state == HUNT) ? out_byte_en : '0);
    for (int i = 0; i < LANES; i++) begin
      sb_ne[i]   = sb_cnt[i] != '0;
      sb_full[i] = sb_cnt[i] == SCW'(SKEW_MAX);
      arm_hit[i] = lane_valid[i] & ~lane_seen[i] & arm_ok[i] &
                   (lane_data[8*i +: 8] == SYNC_BYTE);
      sb_push[i] = armed[i] & lane_valid[i] & ((state == HUNT) || (state == STREAM));
      if (out_byte_en[i]) word_asm[8*i +: 8] = sb_mem[i][sb_rp[i]];
    end
    all_ne    = &(sb_ne | ~out_byte_en);
    all_armed = &(armed | arm_hit | ~out_byte_en);
    lv_idle   = ~|(lane_valid & out_byte_en);
    sb_ovf    = |(sb_push & sb_full);
    cnt_inc   = SCW'(cnt + 1'b1);
  end

  always_ff @(posedge hs_clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    flush     = 1'b0;
    clr_arm   = 1'b0;
    pop_word  = 1'b0;
    fifo_push = 1'b0;
    push_eop  = 1'b0;
    skew_evt  = 1'b0;
    unique case (state)
      IDLE: if (|arm_hit) begin
        state_nxt = HUNT;
        latch_en  = 1'b1;
      end
      HUNT: begin
        if (sb_ovf || (cnt_inc >= SCW'(SKEW_MAX) && !all_armed) ||
            (all_armed && cnt_inc >= SCW'(SKEW_MAX))) begin
          skew_evt  = 1'b1;
          flush     = 1'b1;
          clr_arm   = 1'b1;
          state_nxt = WAIT_IDLE;
        end else if (all_armed) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (all_ne) begin
          pop_word  = 1'b1;
          fifo_push = stage_v;
        end else if (sb_ovf) begin
          skew_evt  = 1'b1;
          flush     = 1'b1;
          clr_arm   = 1'b1;
          state_nxt = WAIT_IDLE;
        end else if (lv_idle) begin
          // Residual bytes on lanes that ran longer are discarded with the flush.
          fifo_push = stage_v;
          push_eop  = 1'b1;
          flush     = 1'b1;
          clr_arm   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_IDLE: if (lv_idle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hs_clk) begin
    if (rst) begin
      lane_seen   <= '1;
      armed       <= '0;
      cnt         <= '0;
      out_byte_en <= '0;
      first_word  <= 1'b0;
      stage_v     <= 1'b0;
      stage_sop   <= 1'b0;
      stage_data  <= '0;
      skew_err    <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      lane_seen <= lane_valid;
      armed     <= clr_arm ? '0 : (armed | arm_hit);
      cnt       <= latch_en ? '0 : ((state == HUNT) ? cnt_inc : cnt);
      if (latch_en) begin
        out_byte_en <= lane_en;
        first_word  <= 1'b1;
      end
      if (pop_word) begin
        stage_data <= word_asm;
        stage_sop  <= first_word;
        stage_v    <= 1'b1;
        first_word <= 1'b0;
      end else if (flush) begin
        stage_v <= 1'b0;
      end
      skew_err <= skew_evt  | (skew_err & ~err_clr);
      ovf_err  <= fifo_drop | (ovf_err  & ~err_clr);
    end
  end

  // A full skew buffer still accepts a byte in a cycle that also pops it.
  always_comb begin
    for (int i = 0; i < LANES; i++)
      sb_wr[i] = sb_push[i] & ~flush & (~sb_full[i] | (pop_word & out_byte_en[i]));
  end

  always_ff @(posedge hs_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (rst || flush) begin
        sb_wp[i]  <= '0;
        sb_rp[i]  <= '0;
        sb_cnt[i] <= '0;
      end else begin
        if (sb_wr[i]) sb_wp[i] <= wrap_inc(sb_wp[i]);
        if (pop_word && out_byte_en[i]) sb_rp[i] <= wrap_inc(sb_rp[i]);
        if (sb_wr[i] && !(pop_word && out_byte_en[i]))      sb_cnt[i] <= sb_cnt[i] + 1'b1;
        else if (!sb_wr[i] && pop_word && out_byte_en[i]) sb_cnt[i] <= sb_cnt[i] - 1'b1;
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone define valid contents.
  always_ff @(posedge hs_clk) begin
    for (int i = 0; i < LANES; i++)
      if (sb_wr[i]) sb_mem[i][sb_wp[i]] <= lane_data[8*i +: 8];
    if (f_wr) fifo_mem[f_wp] <= {stage_sop, push_eop, stage_data};
  end

  assign f_full    = f_cnt == (FPW+1)'(FIFO_DEPTH);
  assign f_pop     = out_valid & out_ready;
  assign f_wr      = fifo_push & (~f_full | f_pop);
  assign fifo_drop = fifo_push & f_full & ~f_pop;

  always_ff @(posedge hs_clk) begin
    if (rst) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (f_wr)  f_wp <= f_wp + 1'b1;
      if (f_pop) f_rp <= f_rp + 1'b1;
      if (f_wr && !f_pop)      f_cnt <= f_cnt + 1'b1;
      else if (!f_wr && f_pop) f_cnt <= f_cnt - 1'b1;
    end
  end

  assign f_head    = fifo_mem[f_rp];
  assign out_valid = f_cnt != '0;
  assign out_data  = out_valid ? f_head[W-1:0] : '0;
  assign out_sop   = out_valid & f_head[W+1];
  assign out_eop   = out_valid & f_head[W];
  assign busy      = state != IDLE;

endmodule

// File: tb/tb_csi_lane_deskew_merger.sv
// Scoreboard bench for csi_lane_deskew_merger: expected words are queued as bursts are
// driven and compared as the consumer accepts them.
module tb_csi_lane_deskew_merger;

  localparam int LANES = 4;

  logic        hs_clk;
  logic        rst;
  logic [3:0]  lane_en;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [31:0] out_data;
  logic [3:0]  out_byte_en;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic        skew_err, ovf_err, err_clr, busy;

  csi_lane_deskew_merger #(
    .LANES(4), .SKEW_MAX(4), .FIFO_DEPTH(16), .SYNC_BYTE(8'hB8)
  ) dut (
    .hs_clk(hs_clk), .rst(rst), .lane_en(lane_en), .lane_data(lane_data),
    .lane_valid(lane_valid), .out_data(out_data), .out_byte_en(out_byte_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .skew_err(skew_err), .ovf_err(ovf_err), .err_clr(err_clr), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  en;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   sop_cyc  = -1;
  int   t_first  = -1;
  int   dly[4];
  int   rst_at   = -1;
  int   busy_at  = -1;

  initial hs_clk = 1'b0;
  always #5 hs_clk = ~hs_clk;
  always @(posedge hs_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge hs_clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data", out_data, e.data);
        check("sop", {31'b0, out_sop}, {31'b0, e.sop});
        check("eop", {31'b0, out_eop}, {31'b0, e.eop});
        check("byte_en", {28'b0, out_byte_en}, {28'b0, e.en});
        if (out_sop) sop_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge hs_clk);
    #1;
  endtask

  // Lane i byte k carries 0x10*i + k; disabled lanes contribute zero.
  task automatic expect_burst(input int n, input logic [3:0] en, input int max_words);
    for (int k = 0; k < n && k < max_words; k++) begin
      exp_t e;
      e.data = '0;
      for (int i = 0; i < LANES; i++)
        if (en[i]) e.data[8*i +: 8] = 8'(16*i + k);
      e.sop = (k == 0);
      e.eop = (k == n - 1);
      e.en  = en;
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},   {31'b0, out_valid}, 32'd0);
    check({tag, "_sop"},     {31'b0, out_sop}, 32'd0);
    check({tag, "_eop"},     {31'b0, out_eop}, 32'd0);
    check({tag, "_data"},    out_data, 32'd0);
    check({tag, "_byte_en"}, {28'b0, out_byte_en}, 32'd0);
    check({tag, "_skew"},    {31'b0, skew_err}, 32'd0);
    check({tag, "_ovf"},     {31'b0, ovf_err}, 32'd0);
    check({tag, "_busy"},    {31'b0, busy}, 32'd0);
  endtask

  // Each lane: sync at cycle dly[i], then nbytes data bytes, then lane_valid low.
  task automatic drive_burst(input int nbytes);
    int maxd = 0;
    for (int i = 0; i < LANES; i++) if (dly[i] > maxd) maxd = dly[i];
    for (int k = 0; k < maxd + nbytes + 2; k++) begin
      for (int i = 0; i < LANES; i++) begin
        int p = k - dly[i];
        if (p == 0) begin
          lane_valid[i] = 1'b1;
          lane_data[8*i +: 8] = 8'hB8;
        end else if (p >= 1 && p <= nbytes) begin
          lane_valid[i] = 1'b1;
          lane_data[8*i +: 8] = 8'(16*i + p - 1);
        end else begin
          lane_valid[i] = 1'b0;
          lane_data[8*i +: 8] = 8'h00;
        end
      end
      rst = (k == rst_at);
      if (k == maxd + 1) t_first = cyc;
      if (k == busy_at) check("busy_hold", {31'b0, busy}, 32'd1);
      if (rst_at >= 0 && k == rst_at + 1) check_reset_values("midrst");
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) tick();
    check("drain_left", sb.size(), 32'd0);
    repeat (4) tick();
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  initial begin
    rst = 1'b1; lane_en = 4'hF; lane_valid = '0; lane_data = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    set_dly(0, 0, 0, 0);
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    repeat (3) tick();

    // Aligned lanes, 8 bytes each; first word sop 0x30201000, last eop 0x37271707.
    expect_burst(8, 4'hF, 99);
    sop_cyc = -1;
    drive_burst(8);
    wait_drain(50);
    check("latency", sop_cyc - t_first, 32'd3);
    check("t1_skew", {31'b0, skew_err}, 32'd0);
    check("t1_ovf", {31'b0, ovf_err}, 32'd0);
    check("t1_busy", {31'b0, busy}, 32'd0);

    // Lane 2 sync three cycles late: tolerated.
    set_dly(0, 0, 3, 0);
    expect_burst(8, 4'hF, 99);
    sop_cyc = -1;
    drive_burst(8);
    wait_drain(50);
    check("t2_skew", {31'b0, skew_err}, 32'd0);
    check("t2_latency", sop_cyc - t_first, 32'd3);

    // Lane 1 sync four cycles late: skew error, no words, busy until lanes drop.
    set_dly(0, 4, 0, 0);
    busy_at = 12;
    drive_burst(8);
    busy_at = -1;
    repeat (2) tick();
    check("t3_skew", {31'b0, skew_err}, 32'd1);
    check("t3_busy", {31'b0, busy}, 32'd0);
    check("t3_words", sb.size(), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_clr", {31'b0, skew_err}, 32'd0);

    // 20-word burst into a stalled consumer: first 16 words kept, rest dropped.
    set_dly(0, 0, 0, 0);
    out_ready = 1'b0;
    expect_burst(20, 4'hF, 16);
    drive_burst(20);
    repeat (3) tick();
    check("t4_ovf", {31'b0, ovf_err}, 32'd1);
    check("t4_valid", {31'b0, out_valid}, 32'd1);
    check("t4_skew", {31'b0, skew_err}, 32'd0);
    out_ready = 1'b1;
    wait_drain(60);
    check("t4_empty", {31'b0, out_valid}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr", {31'b0, ovf_err}, 32'd0);

    // Only lanes 0/1 enabled; lanes 2/3 carry traffic that must be ignored.
    lane_en = 4'b0011;
    expect_burst(2, 4'b0011, 99);
    drive_burst(2);
    wait_drain(40);
    check("t5_byte_en", {28'b0, out_byte_en}, 32'h3);
    lane_en = 4'hF;

    // Reset mid-stream: nothing from that burst may appear, then a clean burst.
    rst_at = 3;
    drive_burst(10);
    rst_at = -1;
    repeat (6) tick();
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_valid", {31'b0, out_valid}, 32'd0);
    expect_burst(3, 4'hF, 99);
    drive_burst(3);
    wait_drain(40);
    check("t6_err", {30'b0, skew_err, ovf_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
